// File: rtl/ex_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ex_pkg
// Description : Shared codes for the ex2_muldiv execute stage: mul/div opcodes,
//               forward-select codes, ALU control codes, MD FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package ex_pkg;

  // Multiply/divide operation codes carried on EX_inmdop
  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MFHI  = 3'd5;
  localparam logic [2:0] MD_MFLO  = 3'd6;
  localparam logic [2:0] MD_MT    = 3'd7;  // mthi, or mtlo when rd[0]=1

  // Operand forward-select codes
  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  // ALU control codes
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;
  localparam logic [3:0] ALU_LUI  = 4'b1010;
  localparam logic [3:0] ALU_NOR  = 4'b1100;

  localparam int LINK_REG_DEFAULT = 31;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  // True for the four opcodes that start the iterative unit
  function automatic logic is_md_issue(input logic [2:0] op);
    return (op >= MD_MULT) && (op <= MD_DIVU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative shift-add multiplier / restoring divider with HI/LO
//               registers and a pipeline stall handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit
  import ex_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_valid,
  input  logic            i_flush,
  input  logic [2:0]      i_mdop,
  input  logic            i_mt_lo,
  input  logic [XLEN-1:0] i_rs,
  input  logic [XLEN-1:0] i_rt,
  output logic [XLEN-1:0] o_hi,
  output logic [XLEN-1:0] o_lo,
  output logic            o_stall,
  output logic            o_busy
);

  localparam int CW = $clog2(XLEN + 1);

  md_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [XLEN-1:0] acc_q, acc_d;    // partial product high half / remainder
  logic [XLEN-1:0] mq_q, mq_d;      // multiplier-product low half / dividend-quotient
  logic [XLEN-1:0] b_q, b_d;        // multiplicand / divisor magnitude
  logic            div_q, div_d;
  logic            qneg_q, qneg_d;  // product or quotient must be negated
  logic            rneg_q, rneg_d;  // remainder must be negated

  logic            w_issue, w_is_div, w_signed, w_sa, w_sb, w_stall;
  logic [XLEN-1:0] w_amag, w_bmag, w_step_acc, w_step_mq;
  logic [XLEN:0]   w_sum, w_shift, w_diff;
  logic [2*XLEN-1:0] w_prod;

  // One iteration of multiply or divide from the current working registers
  always_comb begin
    w_sum   = {1'b0, acc_q} + (mq_q[0] ? {1'b0, b_q} : '0);
    w_shift = {acc_q, mq_q[XLEN-1]};
    w_diff  = w_shift - {1'b0, b_q};
    if (div_q) begin
      w_step_acc = w_diff[XLEN] ? w_shift[XLEN-1:0] : w_diff[XLEN-1:0];
      w_step_mq  = {mq_q[XLEN-2:0], ~w_diff[XLEN]};
    end else begin
      w_step_acc = w_sum[XLEN:1];
      w_step_mq  = {w_sum[0], mq_q[XLEN-1:1]};
    end
    w_prod = {w_step_acc, w_step_mq};
  end

  // FSM next-state, datapath update and stall generation
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    acc_d   = acc_q;
    mq_d    = mq_q;
    b_d     = b_q;
    div_d   = div_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    w_stall = 1'b0;

    w_issue  = i_valid && !i_flush && is_md_issue(i_mdop);
    w_is_div = (i_mdop == MD_DIV) || (i_mdop == MD_DIVU);
    w_signed = (i_mdop == MD_MULT) || (i_mdop == MD_DIV);
    w_sa     = w_signed && i_rs[XLEN-1];
    w_sb     = w_signed && i_rt[XLEN-1];
    w_amag   = w_sa ? -i_rs : i_rs;
    w_bmag   = w_sb ? -i_rt : i_rt;

    case (state_q)
      MD_IDLE: begin
        if (w_issue) begin
          w_stall = 1'b1;
          if (w_is_div && (i_rt == '0)) begin
            // Divide by zero resolves immediately with a fixed result
            hi_d    = i_rs;
            lo_d    = '1;
            state_d = MD_DONE;
          end else begin
            acc_d   = '0;
            mq_d    = w_amag;
            b_d     = w_bmag;
            div_d   = w_is_div;
            qneg_d  = w_sa ^ w_sb;
            rneg_d  = w_sa;
            cnt_d   = CW'(XLEN);
            state_d = MD_BUSY;
          end
        end else if (i_valid && !i_flush && (i_mdop == MD_MT)) begin
          if (i_mt_lo) lo_d = i_rs;
          else         hi_d = i_rs;
        end
      end
      MD_BUSY: begin
        if (i_flush) begin
          // Killed instruction: abandon the operation, HI/LO untouched
          cnt_d   = '0;
          state_d = MD_IDLE;
        end else begin
          w_stall = 1'b1;
          acc_d   = w_step_acc;
          mq_d    = w_step_mq;
          cnt_d   = cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            state_d = MD_DONE;
            if (div_q) begin
              lo_d = qneg_q ? -w_step_mq  : w_step_mq;
              hi_d = rneg_q ? -w_step_acc : w_step_acc;
            end else begin
              {hi_d, lo_d} = qneg_q ? -w_prod : w_prod;
            end
          end
        end
      end
      MD_DONE: state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  // State and HI/LO registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      acc_q   <= '0;
      mq_q    <= '0;
      b_q     <= '0;
      div_q   <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      acc_q   <= acc_d;
      mq_q    <= mq_d;
      b_q     <= b_d;
      div_q   <= div_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
    end
  end

  assign o_hi    = hi_q;
  assign o_lo    = lo_q;
  assign o_stall = w_stall && !rst;
  assign o_busy  = (state_q != MD_IDLE);

endmodule
`default_nettype wire

// File: rtl/ex2_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : ex2_muldiv
// Description : MIPS execute stage: destination select, link override,
//               two-level forwarding, ALU operand muxes, main ALU, plus the
//               iterative multiply/divide unit with HI/LO.
// Revision    : 1.0 - initial release
// ============================================================================
module ex2_muldiv
  import ex_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int RBITS    = 5,
  parameter int LINK_REG = LINK_REG_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             EX_invalid,
  input  logic             EX_inflush,
  input  logic [RBITS-1:0] EX_inIDEXREGISTERRS,
  input  logic [RBITS-1:0] EX_inIDEXREGISTERRT,
  input  logic [RBITS-1:0] EX_inIDEXREGISTERRD,
  input  logic             EX_inREGDEST,
  input  logic [RBITS-1:0] EX_inEXMEMREGISTERRDRT,
  input  logic [RBITS-1:0] EX_inMEMWBREGISTERRDRT,
  input  logic             EX_inEXMEMREGWRITE,
  input  logic             EX_inMEMWBREGWRITE,
  input  logic             EX_injalsig,
  input  logic             EX_injalrsig,
  input  logic             EX_inbalal,
  input  logic [XLEN-1:0]  EX_infromRs,
  input  logic [XLEN-1:0]  EX_infromRt,
  input  logic [XLEN-1:0]  EX_infromEXMEM,
  input  logic [XLEN-1:0]  EX_infromMEMWB,
  input  logic [4:0]       EX_infromshamt,
  input  logic             EX_inshamtsignal,
  input  logic [XLEN-1:0]  EX_iniformat,
  input  logic             EX_inALUSRC,
  input  logic [3:0]       EX_infromALUctl,
  input  logic [3:0]       EX_infromIALUctl,
  input  logic [2:0]       EX_inmdop,
  output logic [XLEN-1:0]  EX_outanswer,
  output logic             EX_outtoANDLINK,
  output logic [RBITS-1:0] EX_outtopipereg5,
  output logic [XLEN-1:0]  EX_outfboutpipe,
  output logic             EX_outstall,
  output logic             EX_outbusy
);

  logic [1:0]      fwd_a_sel, fwd_b_sel;
  logic [XLEN-1:0] fwd_a, fwd_b, alu_a, alu_b, alu_res, md_hi, md_lo;
  logic [3:0]      alu_ctl;
  logic [4:0]      sh;

  // Forward selection: EX/MEM beats MEM/WB, register 0 is never forwarded
  always_comb begin
    fwd_a_sel = FWD_REG;
    fwd_b_sel = FWD_REG;
    if (EX_inEXMEMREGWRITE && (EX_inEXMEMREGISTERRDRT != '0) &&
        (EX_inEXMEMREGISTERRDRT == EX_inIDEXREGISTERRS))
      fwd_a_sel = FWD_EXMEM;
    else if (EX_inMEMWBREGWRITE && (EX_inMEMWBREGISTERRDRT != '0) &&
             (EX_inMEMWBREGISTERRDRT == EX_inIDEXREGISTERRS))
      fwd_a_sel = FWD_MEMWB;
    if (EX_inEXMEMREGWRITE && (EX_inEXMEMREGISTERRDRT != '0) &&
        (EX_inEXMEMREGISTERRDRT == EX_inIDEXREGISTERRT))
      fwd_b_sel = FWD_EXMEM;
    else if (EX_inMEMWBREGWRITE && (EX_inMEMWBREGISTERRDRT != '0) &&
             (EX_inMEMWBREGISTERRDRT == EX_inIDEXREGISTERRT))
      fwd_b_sel = FWD_MEMWB;
  end

  // Forwarded operands and ALU input muxes; immediate ops use the I-type control
  always_comb begin
    case (fwd_a_sel)
      FWD_EXMEM: fwd_a = EX_infromEXMEM;
      FWD_MEMWB: fwd_a = EX_infromMEMWB;
      default:   fwd_a = EX_infromRs;
    endcase
    case (fwd_b_sel)
      FWD_EXMEM: fwd_b = EX_infromEXMEM;
      FWD_MEMWB: fwd_b = EX_infromMEMWB;
      default:   fwd_b = EX_infromRt;
    endcase
    alu_a   = EX_inshamtsignal ? {{(XLEN-5){1'b0}}, EX_infromshamt} : fwd_a;
    alu_b   = EX_inALUSRC ? EX_iniformat : fwd_b;
    alu_ctl = EX_inALUSRC ? EX_infromIALUctl : EX_infromALUctl;
    sh      = alu_a[4:0];
  end

  // Main ALU; shifts move operand B by operand A
  always_comb begin
    case (alu_ctl)
      ALU_AND:  alu_res = alu_a & alu_b;
      ALU_OR:   alu_res = alu_a | alu_b;
      ALU_ADD:  alu_res = alu_a + alu_b;
      ALU_XOR:  alu_res = alu_a ^ alu_b;
      ALU_SLL:  alu_res = alu_b << sh;
      ALU_SRL:  alu_res = alu_b >> sh;
      ALU_SUB:  alu_res = alu_a - alu_b;
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
      ALU_SRA:  alu_res = $signed(alu_b) >>> sh;
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (alu_a < alu_b)};
      ALU_LUI:  alu_res = alu_b << (XLEN / 2);
      ALU_NOR:  alu_res = ~(alu_a | alu_b);
      default:  alu_res = '0;
    endcase
  end

  // Destination select with link override, result select for mfhi/mflo
  always_comb begin
    EX_outtoANDLINK  = EX_injalsig | EX_injalrsig | EX_inbalal;
    EX_outtopipereg5 = EX_inREGDEST ? EX_inIDEXREGISTERRD : EX_inIDEXREGISTERRT;
    if (EX_outtoANDLINK) EX_outtopipereg5 = RBITS'(LINK_REG);
    case (EX_inmdop)
      MD_MFHI: EX_outanswer = md_hi;
      MD_MFLO: EX_outanswer = md_lo;
      default: EX_outanswer = alu_res;
    endcase
  end

  assign EX_outfboutpipe = fwd_b;

  muldiv_unit #(
    .XLEN (XLEN)
  ) u_muldiv (
    .clk     (clk),
    .rst     (reset),
    .i_valid (EX_invalid),
    .i_flush (EX_inflush),
    .i_mdop  (EX_inmdop),
    .i_mt_lo (EX_inIDEXREGISTERRD[0]),
    .i_rs    (fwd_a),
    .i_rt    (fwd_b),
    .o_hi    (md_hi),
    .o_lo    (md_lo),
    .o_stall (EX_outstall),
    .o_busy  (EX_outbusy)
  );

endmodule
`default_nettype wire

// File: doc/ex2_muldiv.md
Name: ex2_muldiv

Overview:
- Next-generation execute stage for the pipelined MIPS core.
- Keeps the existing EX datapath: destination select, link override, two-level forwarding, shamt mux, ALUSrc mux, main ALU.
- Adds an XLEN-parametrised iterative multiply/divide unit with HI/LO registers and a stall handshake to the hazard unit.
- Sits between the ID/EX and EX/MEM pipeline registers. ALU results stay combinational; HI/LO and the MD FSM are sequential.

Parameters:
- XLEN, 32, datapath width (operands, ALU, HI, LO); must be even, >= 8.
- RBITS, 5, register index width.
- LINK_REG, 31, destination index forced for jal/jalr/bal-and-link.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- EX_invalid  in  1  ID/EX holds a live instruction
- EX_inflush  in  1  kill the instruction in EX (branch/exception)
- EX_inIDEXREGISTERRS, EX_inIDEXREGISTERRT, EX_inIDEXREGISTERRD  in  RBITS  source/dest indices
- EX_inREGDEST  in  1  1 = rd, 0 = rt
- EX_inEXMEMREGISTERRDRT, EX_inMEMWBREGISTERRDRT  in  RBITS  later-stage dest indices
- EX_inEXMEMREGWRITE, EX_inMEMWBREGWRITE  in  1  later-stage write enables
- EX_injalsig, EX_injalrsig, EX_inbalal  in  1  link controls
- EX_infromRs, EX_infromRt, EX_infromEXMEM, EX_infromMEMWB  in  XLEN  operand and forward data
- EX_infromshamt  in  5  shift amount
- EX_inshamtsignal  in  1  1 = ALU A is zero-extended shamt
- EX_iniformat  in  XLEN  extended immediate
- EX_inALUSRC  in  1  1 = ALU B is immediate
- EX_infromALUctl, EX_infromIALUctl  in  4  ALU controls, unchanged encoding
- EX_inmdop  in  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi/mtlo; mtlo when EX_inIDEXREGISTERRD[0]=1
- EX_outanswer  out  XLEN  ALU result, or HI/LO for mfhi/mflo
- EX_outtoANDLINK  out  1  OR of the three link controls
- EX_outtopipereg5  out  RBITS  final destination index
- EX_outfboutpipe  out  XLEN  forwarded Rt (store data)
- EX_outstall  out  1  hold PC, IF/ID, ID/EX; bubble into EX/MEM
- EX_outbusy  out  1  MD FSM not IDLE

Behaviour:
- Forwarding, per operand:
  - EX/MEM match (regwrite=1, index!=0, index==src) selects EX_infromEXMEM.
  - Otherwise MEM/WB match selects EX_infromMEMWB.
  - Otherwise use the register-file value.
  - Index 0 is never forwarded.
- Destination: REGDEST mux, then LINK_REG if any link control is 1.
- MD FSM states: IDLE, BUSY, DONE. Reset: IDLE, HI=LO=0, counter=0, stall=0, busy=0.
- IDLE to BUSY: when EX_invalid & !EX_inflush & mdop in 1..4.
  - Latch forwarded A/B magnitudes and result sign.
  - Load counter=XLEN; stall=1 in the issue cycle.
- BUSY:
  - mult: shift-add, one bit per cycle.
  - div: restoring, one quotient bit per cycle.
  - Decrement counter; stall=1.
  - When counter reaches 1, the next edge writes HI/LO (sign-corrected) and goes to DONE.
  - Total stall cycles = XLEN+1.
- DONE: stall=0 so the instruction leaves EX. Unconditionally return to IDLE; no restart on the same instruction.
- Results:
  - mult/multu: {HI,LO} = 2*XLEN-bit product.
  - div/divu: LO = quotient, HI = remainder; remainder takes the dividend's sign.
- Divide by zero:
  - Skip BUSY; IDLE to DONE in one cycle, stall=1 for that cycle.
  - HI = dividend, LO = all ones.
- Signed overflow (most-negative / -1): LO = most-negative, HI = 0. No trap.
- mfhi/mflo:
  - If state != IDLE, stall=1 until DONE.
  - Otherwise EX_outanswer = HI/LO combinationally.
- mthi/mtlo:
  - Write on the edge when IDLE & valid & !flush.
  - A simultaneous mult/div issue is impossible (single instruction).
- EX_inflush:
  - During issue: no start.
  - During BUSY: return to IDLE next edge, HI/LO unchanged, stall=0 that cycle.
- reset mid-BUSY: IDLE next edge, HI/LO cleared.
- All non-MD paths are combinational, zero latency, identical to the current EX stage.

Decomposition:
- Package ex_pkg: mdop codes, forward-select codes (00 reg, 10 EX/MEM, 01 MEM/WB), ALU ctl codes, MD state enum, LINK_REG default.
- Sub-module muldiv_unit (XLEN): FSM, counter, HI/LO, stall/busy.
- The top instantiates the existing mux/forwarding/ALU blocks plus muldiv_unit.

Test Plan:
- Forward priority: rs=3; EX/MEM rd=3 regwrite=1 data=0x11; MEM/WB rd=3 data=0x22; add -> A=0x11. Repeat with rs=0 -> register value used.
- mult -3 * 5, XLEN=32: stall high exactly 33 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFF1, busy low after DONE.
- div -7 / 2: LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 7 / 0: one stall cycle, HI=7, LO=0xFFFFFFFF.
- mflo issued during BUSY: stalls until DONE, then EX_outanswer = new LO.
- flush at BUSY cycle 10: IDLE next edge, HI/LO keep prior values, stall low. Reset at cycle 5: HI=LO=0.
- jal with REGDEST=1, rd=8: EX_outtopipereg5=31, EX_outtoANDLINK=1. Rerun the mult test with XLEN=16: 17 stall cycles.
